// File: rtl/wb_lane_pipe.sv
// N-lane EX->MEM->WB result pipeline with operand forwarding, late-result
// merge in MEM, load-use detection and redirect/flush squashing of EX lanes.
module wb_lane_pipe #(
   parameter int LANES = 2,
   parameter int XLEN  = 32,
   parameter int AW    = 5,
   parameter int LW    = (LANES > 1) ? $clog2(LANES) : 1
) (
   input  logic                      clk,
   input  logic                      rstn,
   input  logic                      stall,
   input  logic                      flush,
   input  logic [LANES-1:0]          ex_valid,
   input  logic [LANES-1:0]          ex_we,
   input  logic [LANES*AW-1:0]       ex_waddr,
   input  logic [LANES*XLEN-1:0]     ex_wdata,
   input  logic [LANES-1:0]          ex_late,
   input  logic [LANES*2*AW-1:0]     ex_raddr,
   input  logic [LANES*2*XLEN-1:0]   ex_rdata,
   input  logic                      redirect,
   input  logic [LW-1:0]             redirect_lane,
   input  logic [LANES*XLEN-1:0]     mem_late_data,
   output logic [LANES*2*XLEN-1:0]   ex_fwd_data,
   output logic [LANES-1:0]          load_use,
   output logic                      redirect_fire,
   output logic [LANES-1:0]          mem_we,
   output logic [LANES*AW-1:0]       mem_waddr,
   output logic [LANES-1:0]          wb_we,
   output logic [LANES*AW-1:0]       wb_waddr,
   output logic [LANES*XLEN-1:0]     wb_wdata
);

   logic [LANES-1:0] mem_v_r;
   logic [LANES-1:0] mem_we_r;
   logic [LANES-1:0] mem_late_r;
   logic [AW-1:0]    mem_waddr_r [LANES];
   logic [XLEN-1:0]  mem_data_r  [LANES];
   logic [LANES-1:0] wb_we_r;
   logic [AW-1:0]    wb_waddr_r  [LANES];
   logic [XLEN-1:0]  wb_wdata_r  [LANES];
   logic [LANES-1:0] kill_pend_r;
   logic             redir_done_r;

   logic [LANES-1:0] kill_now_s;
   logic [LANES-1:0] kill_s;
   logic [LANES-1:0] mem_hit_s;
   logic [XLEN-1:0]  fwd_val_s;
   logic             fwd_late_s;
   logic             fwd_hit_s;
   logic [AW-1:0]    fwd_ra_s;

   assign redirect_fire = redirect & ~redir_done_r;
   assign mem_we        = mem_hit_s;
   assign wb_we         = wb_we_r;

   // Kill mask for the next advancing edge and effective MEM-stage writes
   always_comb begin
      kill_now_s = {LANES{1'b0}};
      mem_hit_s  = {LANES{1'b0}};
      for (int i = 0; i < LANES; i++) begin
         kill_now_s[i] = flush | (redirect & (LW'(i) > redirect_lane));
         mem_hit_s[i]  = mem_v_r[i] & mem_we_r[i] & (mem_waddr_r[i] != {AW{1'b0}});
      end
      kill_s = kill_pend_r | kill_now_s;
   end

   // MEM stage register: capture EX results with squashed lanes invalidated
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         mem_v_r    <= {LANES{1'b0}};
         mem_we_r   <= {LANES{1'b0}};
         mem_late_r <= {LANES{1'b0}};
         for (int i = 0; i < LANES; i++) begin
            mem_waddr_r[i] <= {AW{1'b0}};
            mem_data_r[i]  <= {XLEN{1'b0}};
         end
      end else if (!stall) begin
         for (int i = 0; i < LANES; i++) begin
            mem_v_r[i]     <= ex_valid[i] & ~kill_s[i];
            mem_we_r[i]    <= ex_we[i];
            mem_late_r[i]  <= ex_late[i];
            mem_waddr_r[i] <= ex_waddr[i*AW +: AW];
            mem_data_r[i]  <= ex_wdata[i*XLEN +: XLEN];
         end
      end
   end

   // WB stage register: late entries take their data from the MEM-side unit
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wb_we_r <= {LANES{1'b0}};
         for (int i = 0; i < LANES; i++) begin
            wb_waddr_r[i] <= {AW{1'b0}};
            wb_wdata_r[i] <= {XLEN{1'b0}};
         end
      end else if (!stall) begin
         for (int i = 0; i < LANES; i++) begin
            wb_we_r[i]    <= mem_hit_s[i];
            wb_waddr_r[i] <= mem_waddr_r[i];
            wb_wdata_r[i] <= mem_late_r[i] ? mem_late_data[i*XLEN +: XLEN] : mem_data_r[i];
         end
      end
   end

   // Kills and fired redirects seen during a stall are held until the pipe advances
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         kill_pend_r  <= {LANES{1'b0}};
         redir_done_r <= 1'b0;
      end else if (!stall) begin
         kill_pend_r  <= {LANES{1'b0}};
         redir_done_r <= 1'b0;
      end else begin
         kill_pend_r  <= kill_s;
         redir_done_r <= redir_done_r | redirect_fire;
      end
   end

   // Forwarding: later loop iterations override, so MEM beats WB and younger lanes win
   always_comb begin
      ex_fwd_data = {(LANES*2*XLEN){1'b0}};
      load_use    = {LANES{1'b0}};
      fwd_val_s   = {XLEN{1'b0}};
      fwd_late_s  = 1'b0;
      fwd_hit_s   = 1'b0;
      fwd_ra_s    = {AW{1'b0}};
      for (int i = 0; i < LANES; i++) begin
         for (int s = 0; s < 2; s++) begin
            fwd_ra_s   = ex_raddr[(2*i+s)*AW +: AW];
            fwd_val_s  = ex_rdata[(2*i+s)*XLEN +: XLEN];
            fwd_late_s = 1'b0;
            for (int j = 0; j < LANES; j++) begin
               fwd_hit_s = wb_we_r[j] & (wb_waddr_r[j] == fwd_ra_s);
               fwd_val_s = fwd_hit_s ? wb_wdata_r[j] : fwd_val_s;
            end
            for (int j = 0; j < LANES; j++) begin
               fwd_hit_s  = mem_hit_s[j] & (mem_waddr_r[j] == fwd_ra_s);
               fwd_val_s  = fwd_hit_s ? mem_data_r[j] : fwd_val_s;
               fwd_late_s = fwd_hit_s ? mem_late_r[j] : fwd_late_s;
            end
            fwd_hit_s  = (fwd_ra_s == {AW{1'b0}});
            fwd_val_s  = fwd_hit_s ? {XLEN{1'b0}} : fwd_val_s;
            fwd_late_s = fwd_hit_s ? 1'b0 : fwd_late_s;
            ex_fwd_data[(2*i+s)*XLEN +: XLEN] = fwd_val_s;
            load_use[i] = load_use[i] | fwd_late_s;
         end
      end
   end

   // Flatten stage state onto the packed output buses
   always_comb begin
      mem_waddr = {(LANES*AW){1'b0}};
      wb_waddr  = {(LANES*AW){1'b0}};
      wb_wdata  = {(LANES*XLEN){1'b0}};
      for (int i = 0; i < LANES; i++) begin
         mem_waddr[i*AW +: AW]  = mem_waddr_r[i];
         wb_waddr[i*AW +: AW]   = wb_waddr_r[i];
         wb_wdata[i*XLEN +: XLEN] = wb_wdata_r[i];
      end
   end

endmodule

// File: tb/tb_wb_lane_pipe.sv
// Bench for wb_lane_pipe (LANES=2): directed scenarios with literal expectations
// plus a per-cycle comparison against a register-write-level reference model.
module tb_wb_lane_pipe;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic          stall, flush, redirect;
   logic [0:0]    redirect_lane;
   logic [1:0]    ex_valid, ex_we, ex_late;
   logic [9:0]    ex_waddr;
   logic [63:0]   ex_wdata;
   logic [19:0]   ex_raddr;
   logic [127:0]  ex_rdata;
   logic [63:0]   mem_late_data;
   logic [127:0]  ex_fwd_data;
   logic [1:0]    load_use;
   logic          redirect_fire;
   logic [1:0]    mem_we;
   logic [9:0]    mem_waddr;
   logic [1:0]    wb_we;
   logic [9:0]    wb_waddr;
   logic [63:0]   wb_wdata;

   int checks = 0;
   int errors = 0;

   wb_lane_pipe #(.LANES(2), .XLEN(32), .AW(5)) dut (
      .clk(clk), .rstn(rstn), .stall(stall), .flush(flush),
      .ex_valid(ex_valid), .ex_we(ex_we), .ex_waddr(ex_waddr), .ex_wdata(ex_wdata),
      .ex_late(ex_late), .ex_raddr(ex_raddr), .ex_rdata(ex_rdata),
      .redirect(redirect), .redirect_lane(redirect_lane), .mem_late_data(mem_late_data),
      .ex_fwd_data(ex_fwd_data), .load_use(load_use), .redirect_fire(redirect_fire),
      .mem_we(mem_we), .mem_waddr(mem_waddr),
      .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata)
   );

   always #5 clk = ~clk;

   task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: each stage is a set of pending register writes
   typedef struct {
      bit          w;
      logic [4:0]  a;
      logic [31:0] d;
      bit          late;
   } ent_t;

   ent_t     m_mem [2];
   ent_t     m_wb  [2];
   bit [1:0] m_pend;
   bit       m_done;

   function automatic bit kill_of(int l);
      return m_pend[l] | flush | (redirect && (l > int'(redirect_lane)));
   endfunction

   // Model update at each active edge, mirroring the async reset
   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int l = 0; l < 2; l++) begin
            m_mem[l] <= '{1'b0, 5'd0, 32'd0, 1'b0};
            m_wb[l]  <= '{1'b0, 5'd0, 32'd0, 1'b0};
         end
         m_pend <= 2'b00;
         m_done <= 1'b0;
      end else if (!stall) begin
         for (int l = 0; l < 2; l++) begin
            m_wb[l].w    <= m_mem[l].w;
            m_wb[l].a    <= m_mem[l].a;
            m_wb[l].d    <= m_mem[l].late ? mem_late_data[l*32 +: 32] : m_mem[l].d;
            m_wb[l].late <= 1'b0;
            m_mem[l].w   <= ex_valid[l] && ex_we[l] && !kill_of(l) && (ex_waddr[l*5 +: 5] != 5'd0);
            m_mem[l].a   <= ex_waddr[l*5 +: 5];
            m_mem[l].d   <= ex_wdata[l*32 +: 32];
            m_mem[l].late <= ex_late[l];
         end
         m_pend <= 2'b00;
         m_done <= 1'b0;
      end else begin
         m_pend <= m_pend | {kill_of(1), kill_of(0)};
         m_done <= m_done | redirect;
      end
   end

   // Expected operand: youngest MEM write, then youngest WB write, else RF value
   task automatic fwd_exp(input int l, input int s, output logic [31:0] v, output bit lt);
      logic [4:0] ra;
      bit found;
      ra = ex_raddr[(2*l+s)*5 +: 5];
      v  = ex_rdata[(2*l+s)*32 +: 32];
      lt = 1'b0;
      found = 1'b0;
      if (ra == 5'd0) begin
         v = 32'd0;
         found = 1'b1;
      end
      for (int j = 1; j >= 0; j--) begin
         if (!found && m_mem[j].w && m_mem[j].a == ra) begin
            v = m_mem[j].d; lt = m_mem[j].late; found = 1'b1;
         end
      end
      for (int j = 1; j >= 0; j--) begin
         if (!found && m_wb[j].w && m_wb[j].a == ra) begin
            v = m_wb[j].d; found = 1'b1;
         end
      end
   endtask

   // Per-cycle comparison of all outputs against the model
   always @(negedge clk) begin
      logic [31:0] v;
      bit lt;
      bit [1:0] lu;
      lu = 2'b00;
      for (int l = 0; l < 2; l++) begin
         for (int s = 0; s < 2; s++) begin
            fwd_exp(l, s, v, lt);
            lu[l] = lu[l] | lt;
            if (!lt) chk($sformatf("fwd[%0d][%0d]", l, s), 64'(ex_fwd_data[(2*l+s)*32 +: 32]), 64'(v));
         end
         chk($sformatf("mem_we[%0d]", l), 64'(mem_we[l]), 64'(m_mem[l].w));
         if (m_mem[l].w) chk($sformatf("mem_waddr[%0d]", l), 64'(mem_waddr[l*5 +: 5]), 64'(m_mem[l].a));
         chk($sformatf("wb_we[%0d]", l), 64'(wb_we[l]), 64'(m_wb[l].w));
         if (m_wb[l].w) begin
            chk($sformatf("wb_waddr[%0d]", l), 64'(wb_waddr[l*5 +: 5]), 64'(m_wb[l].a));
            chk($sformatf("wb_wdata[%0d]", l), 64'(wb_wdata[l*32 +: 32]), 64'(m_wb[l].d));
         end
      end
      chk("load_use", 64'(load_use), 64'(lu));
      chk("redirect_fire", 64'(redirect_fire), 64'(redirect && !m_done));
   end

   task automatic clr();
      ex_valid = 2'b00; ex_we = 2'b00; ex_late = 2'b00;
      ex_waddr = 10'd0; ex_wdata = 64'd0; ex_raddr = 20'd0; ex_rdata = 128'd0;
      mem_late_data = 64'd0; stall = 1'b0; flush = 1'b0;
      redirect = 1'b0; redirect_lane = 1'b0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      clr();
   endtask

   task automatic lane(int l, bit v, bit we, logic [4:0] wa, logic [31:0] wd, bit lt);
      ex_valid[l] = v; ex_we[l] = we; ex_late[l] = lt;
      ex_waddr[l*5 +: 5] = wa;
      ex_wdata[l*32 +: 32] = wd;
   endtask

   task automatic src(int l, int s, logic [4:0] ra, logic [31:0] rd);
      ex_raddr[(2*l+s)*5 +: 5] = ra;
      ex_rdata[(2*l+s)*32 +: 32] = rd;
   endtask

   function automatic logic [31:0] fwd(int l, int s);
      return ex_fwd_data[(2*l+s)*32 +: 32];
   endfunction

   initial begin
      clr();
      repeat (2) @(posedge clk);
      #3;
      chk("reset wb_we", 64'(wb_we), 64'd0);
      chk("reset mem_we", 64'(mem_we), 64'd0);
      chk("reset redirect_fire", 64'(redirect_fire), 64'd0);

      step(); rstn = 1'b1; lane(0, 1'b1, 1'b1, 5'd5, 32'h11, 1'b0);
      step(); src(1, 0, 5'd5, 32'h99);
      lane(0, 1'b1, 1'b1, 5'd7, 32'hA, 1'b0); lane(1, 1'b1, 1'b1, 5'd7, 32'hB, 1'b0);
      #2; chk("r5 from MEM", 64'(fwd(1, 0)), 64'h11); chk("mem_we r5", 64'(mem_we), 64'h1);
      step(); src(0, 0, 5'd5, 32'h0); src(0, 1, 5'd7, 32'h55);
      lane(0, 1'b1, 1'b1, 5'd3, 32'h5555, 1'b1);
      #2; chk("r5 from WB", 64'(fwd(0, 0)), 64'h11); chk("r7 younger lane", 64'(fwd(0, 1)), 64'hB);
      chk("wb_wdata r5", 64'(wb_wdata[31:0]), 64'h11);
      step(); lane(0, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0); src(0, 0, 5'd3, 32'h0);
      mem_late_data[31:0] = 32'hDEAD;
      #2; chk("load_use late r3", 64'(load_use), 64'h1);
      step(); src(0, 0, 5'd3, 32'h0); redirect = 1'b1; redirect_lane = 1'b0;
      lane(0, 1'b1, 1'b1, 5'd8, 32'h1, 1'b0); lane(1, 1'b1, 1'b1, 5'd9, 32'h2, 1'b0);
      #2; chk("late r3 via WB", 64'(fwd(0, 0)), 64'hDEAD); chk("load_use clear", 64'(load_use), 64'h0);
      chk("redirect fire", 64'(redirect_fire), 64'h1);
      step(); #2; chk("mem_we squash", 64'(mem_we), 64'h1);
      step(); stall = 1'b1; redirect = 1'b1; redirect_lane = 1'b0;
      lane(0, 1'b1, 1'b1, 5'd10, 32'h3, 1'b0); lane(1, 1'b1, 1'b1, 5'd11, 32'h4, 1'b0);
      #2; chk("wb_we squash", 64'(wb_we), 64'h1); chk("held fire first", 64'(redirect_fire), 64'h1);
      for (int k = 0; k < 2; k++) begin
         step(); stall = 1'b1; redirect = 1'b1; redirect_lane = 1'b0;
         lane(0, 1'b1, 1'b1, 5'd10, 32'h3, 1'b0); lane(1, 1'b1, 1'b1, 5'd11, 32'h4, 1'b0);
         #2; chk("held fire once", 64'(redirect_fire), 64'h0);
      end
      step(); lane(0, 1'b1, 1'b1, 5'd10, 32'h3, 1'b0); lane(1, 1'b1, 1'b1, 5'd11, 32'h4, 1'b0);
      step(); lane(0, 1'b1, 1'b1, 5'd0, 32'hFF, 1'b0); lane(1, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0);
      src(1, 0, 5'd0, 32'h77);
      #2; chk("pend kill mem_we", 64'(mem_we), 64'h1); chk("mem_waddr r10", 64'(mem_waddr[4:0]), 64'd10);
      chk("r0 read", 64'(fwd(1, 0)), 64'h0);
      step(); src(1, 1, 5'd0, 32'h1234);
      #2; chk("r0 mem_we", 64'(mem_we), 64'h0); chk("wb_we r10", 64'(wb_we), 64'h1);
      chk("wb_wdata r10", 64'(wb_wdata[31:0]), 64'h3);
      step(); stall = 1'b1; lane(0, 1'b1, 1'b1, 5'd12, 32'hC, 1'b0); lane(1, 1'b1, 1'b1, 5'd13, 32'hD, 1'b0);
      #2; chk("r0 wb_we", 64'(wb_we), 64'h0);
      step(); stall = 1'b1; flush = 1'b1;
      lane(0, 1'b1, 1'b1, 5'd12, 32'hC, 1'b0); lane(1, 1'b1, 1'b1, 5'd13, 32'hD, 1'b0);
      step(); stall = 1'b1; rstn = 1'b0;
      lane(0, 1'b1, 1'b1, 5'd12, 32'hC, 1'b0); lane(1, 1'b1, 1'b1, 5'd13, 32'hD, 1'b0);
      #2; chk("rst wb_we", 64'(wb_we), 64'h0); chk("rst mem_we", 64'(mem_we), 64'h0);
      chk("rst wb_wdata", wb_wdata, 64'h0); chk("rst load_use", 64'(load_use), 64'h0);
      chk("rst redirect_fire", 64'(redirect_fire), 64'h0);
      step(); rstn = 1'b1;
      lane(0, 1'b1, 1'b1, 5'd12, 32'hC, 1'b0); lane(1, 1'b1, 1'b1, 5'd13, 32'hD, 1'b0);
      step(); #2; chk("post-rst mem_we", 64'(mem_we), 64'h3);
      step(); #2; chk("post-rst wb_we", 64'(wb_we), 64'h3); chk("post-rst wb_wdata", 64'(wb_wdata[63:32]), 64'hD);

      for (int k = 0; k < 60; k++) begin
         step();
         stall = ($urandom_range(3) == 0);
         flush = ($urandom_range(15) == 0);
         redirect = ($urandom_range(7) == 0);
         redirect_lane = 1'($urandom_range(1));
         mem_late_data = {$urandom, $urandom};
         for (int l = 0; l < 2; l++) begin
            lane(l, 1'($urandom_range(1)), 1'($urandom_range(1)), 5'($urandom_range(7)),
                 $urandom, 1'($urandom_range(1)));
            for (int s = 0; s < 2; s++) src(l, s, 5'($urandom_range(7)), $urandom);
         end
      end
      repeat (3) step();
      @(negedge clk);
      #1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/wb_lane_pipe.md
# wb_lane_pipe

Parametrised N-lane EX→MEM→WB result pipeline with an integrated operand-forwarding network, the generalised successor of the dual-issue backend register/forward path. It accepts up to LANES per-cycle EX results, carries them through MEM (where late results from load/multiply/divide are merged) to WB register-file write ports. It supplies forwarded source operands back to EX, flags late-result (load-use) hazards, and applies branch-redirect squashing of younger lanes. Redirects arriving during a stall are held and applied exactly once.

## Interface
- LANES, 2, issue width (1..4); lane index order = program order, lane 0 oldest
- XLEN, 32, data width
- AW, 5, register address width; register 0 is hardwired zero
- LW, max(1,$clog2(LANES)), lane index width
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- stall  in  1  freeze all stage registers (dcache miss, divider busy)
- flush  in  1  squash every EX lane on the next advancing edge (exception)
- ex_valid  in  LANES  lane carries an instruction
- ex_we  in  LANES  lane writes RF
- ex_waddr  in  LANES*AW  destination per lane
- ex_wdata  in  LANES*XLEN  ALU result per lane
- ex_late  in  LANES  result supplied in MEM via mem_late_data
- ex_raddr  in  LANES*2*AW  two source addresses per lane
- ex_rdata  in  LANES*2*XLEN  RF read values per source
- redirect  in  1  branch in lane redirect_lane mispredicted
- redirect_lane  in  LW  lane of the mispredicting branch
- mem_late_data  in  LANES*XLEN  late result per MEM lane
- ex_fwd_data  out  LANES*2*XLEN  forwarded source operands
- load_use  out  LANES  lane's source depends on an unforwardable late MEM result
- redirect_fire  out  1  one-cycle redirect request to the front end
- mem_we, mem_waddr  out  LANES, LANES*AW  MEM-stage write info (for issue scoreboard)
- wb_we  out  LANES  RF write enable
- wb_waddr  out  LANES*AW  RF write address
- wb_wdata  out  LANES*XLEN  RF write data

## Operation
- Stages: EX (combinational inputs), MEM register, WB register. Per-lane MEM state: v, we, waddr, late, alu data. WB state: we, waddr, wdata.
- Advance (stall=0): MEM ← EX with kill mask applied; WB ← MEM with wdata = late ? mem_late_data[lane] : alu data. Stall=1: MEM and WB hold (a held WB rewrite is idempotent).
- Effective write: we && v && waddr≠0; waddr 0 never written or forwarded.
- Kill mask: redirect kills lanes > redirect_lane; flush kills all lanes. Sticky register kill_pend accumulates (OR) kills while stall=1; on the advancing edge the mask = kill_pend | current kill, then kill_pend clears.
- redirect_fire = redirect && !redir_done. redir_done sets on a fired redirect with stall=1 and clears on the next advancing edge, so one redirect held through a stall fires exactly once.
- Forwarding per source s of lane i: priority MEM lanes (highest index first), then WB lanes (highest first), then ex_rdata. A hit is an effective write with matching waddr. Raddr 0 returns 0. No intra-EX-bundle forwarding; issue guarantees none is needed.
- load_use[i] = 1 when the selected MEM hit for either source of lane i is a late entry. A younger non-late MEM hit overrides an older late hit. Late data is never forwarded from MEM; it is forwarded from WB.

## Timing
- Reset: all MEM/WB registers, kill_pend and redir_done = 0; wb_we = mem_we = 0; redirect_fire = 0.
- Latency: EX result at edge t appears on wb_* after edge t+1 (2 advancing edges), with stall cycles adding 1 each.
- ex_fwd_data, load_use and redirect_fire are combinational from the current stage state and inputs.
- mem_late_data is sampled only on the advancing edge.
- Reset mid-stall drops pending kills and all in-flight writes.

## Test plan
- LANES=2, lane0 writes r5=0x11, then next cycle lane1 reads r5 → ex_fwd_data = 0x11 from MEM; the cycle after, a read of r5 comes from WB → 0x11.
- MEM lane0 and lane1 both write r7 (0xA, 0xB) → EX read of r7 returns 0xB.
- Lane0 late load to r3 in MEM, EX lane0 reads r3 → load_use[0]=1; after one advance, the WB forward returns mem_late_data 0xDEAD.
- redirect with lane 0 while lane1 writes r9 → wb_we[1]=0 two edges later; wb_we[0]=1.
- redirect held 3 stalled cycles → redirect_fire high only the first cycle; lane1 still squashed on release.
- Write to r0 with data 0xFF → wb_we=0; a read of r0 returns 0. Assert rstn mid-stall → all outputs 0.
